// File: rtl/lcd_cmd_sched.sv
// Command scheduler: buffers host opcodes in a FIFO and issues them one at a time to the LCD controller.
// Optional issue counter output enabled by defining LCD_SCHED_STATS_EN.
module lcd_cmd_sched #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255,
    parameter int GUARD   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 host_cmd,
    input  logic                       host_valid,
    output logic                       host_ready,
    output logic [3:0]                 lcd_cmd,
    output logic                       lcd_cmd_valid,
    input  logic                       lcd_busy,
    input  logic                       lcd_done,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       sched_idle,
    output logic                       sched_done,
    output logic                       err_timeout
`ifdef LCD_SCHED_STATS_EN
    ,
    output logic [15:0]                issue_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WDONE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [3:0]      lcd_cmd_q, lcd_cmd_d;
    logic            lcd_cmd_valid_q, lcd_cmd_valid_d;
    logic [GW-1:0]   guard_q, guard_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            sched_done_q, sched_done_d;
    logic            err_timeout_q, err_timeout_d;
    logic            full, empty, push, pop;

    always_comb begin
        full            = (level_q == LW'(DEPTH));
        empty           = (level_q == '0);
        host_ready      = !full && (state_q != S_DONE);
        push            = host_valid && host_ready;
        pop             = 1'b0;
        state_d         = state_q;
        lcd_cmd_d       = lcd_cmd_q;
        lcd_cmd_valid_d = 1'b0;
        guard_d         = guard_q;
        tmo_d           = tmo_q;
        sched_done_d    = sched_done_q;
        err_timeout_d   = err_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (!empty && !lcd_busy) begin
                    pop             = 1'b1;
                    lcd_cmd_d       = mem_q[rd_ptr_q];
                    lcd_cmd_valid_d = 1'b1;
                    guard_d         = GW'(GUARD);
                    tmo_d           = '0;
                    state_d         = S_WAIT;
                end
            end
            S_WAIT: begin
                // lcd_cmd_q still holds the in-flight opcode here
                if (guard_q != '0) begin
                    guard_d = guard_q - 1'b1;
                end else if (lcd_cmd_q == 4'h0) begin
                    tmo_d   = '0;
                    state_d = S_WDONE;
                end else if (!lcd_busy) begin
                    state_d = S_IDLE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WDONE: begin
                if (lcd_done) begin
                    sched_done_d = 1'b1;
                    state_d      = S_DONE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = S_DONE;
            end
        endcase

        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            level_q         <= '0;
            lcd_cmd_q       <= 4'h0;
            lcd_cmd_valid_q <= 1'b0;
            guard_q         <= '0;
            tmo_q           <= '0;
            sched_done_q    <= 1'b0;
            err_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            level_q         <= level_d;
            lcd_cmd_q       <= lcd_cmd_d;
            lcd_cmd_valid_q <= lcd_cmd_valid_d;
            guard_q         <= guard_d;
            tmo_q           <= tmo_d;
            sched_done_q    <= sched_done_d;
            err_timeout_q   <= err_timeout_d;
        end
    end

    // Storage needs no reset: entries are only read when the level says they are valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= host_cmd;
        end
    end

`ifdef LCD_SCHED_STATS_EN
    logic [15:0] issue_cnt_q, issue_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        if (lcd_cmd_valid_d && (issue_cnt_q != 16'hFFFF)) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt_q <= 16'd0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
`endif

    assign lcd_cmd       = lcd_cmd_q;
    assign lcd_cmd_valid = lcd_cmd_valid_q;
    assign fifo_level    = level_q;
    assign sched_idle    = (state_q == S_IDLE) && empty;
    assign sched_done    = sched_done_q;
    assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Self-checking bench for lcd_cmd_sched: scoreboard of accepted host opcodes checked against issued opcodes.
module tb_lcd_cmd_sched;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 255;
    localparam int GUARD   = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  host_cmd;
    logic        host_valid;
    logic        host_ready;
    logic [3:0]  lcd_cmd;
    logic        lcd_cmd_valid;
    logic        lcd_busy;
    logic        lcd_done;
    logic [3:0]  fifo_level;
    logic        sched_idle;
    logic        sched_done;
    logic        err_timeout;
`ifdef LCD_SCHED_STATS_EN
    logic [15:0] issue_cnt;
`endif

    lcd_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GUARD(GUARD)) dut (
        .clk           (clk),
        .reset         (reset),
        .host_cmd      (host_cmd),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .lcd_cmd       (lcd_cmd),
        .lcd_cmd_valid (lcd_cmd_valid),
        .lcd_busy      (lcd_busy),
        .lcd_done      (lcd_done),
        .fifo_level    (fifo_level),
        .sched_idle    (sched_idle),
        .sched_done    (sched_done),
        .err_timeout   (err_timeout)
`ifdef LCD_SCHED_STATS_EN
        ,
        .issue_cnt     (issue_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         n_push = 0;
    int         n_issue = 0;
    int         bcnt = 0;
    logic [3:0] exp_q [$];
    logic [3:0] exp_cmd;
    logic       busy_prev = 1'b0;

    // Scoreboard: record accepted pushes, compare every issue against the oldest one
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (host_valid && host_ready) begin
                exp_q.push_back(host_cmd);
                n_push++;
            end
            if (lcd_cmd_valid) begin
                n_issue++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected: lcd_cmd=%h issued, required no issue", lcd_cmd);
                end else begin
                    exp_cmd = exp_q.pop_front();
                    if (lcd_cmd !== exp_cmd) begin
                        errors++;
                        $display("FAIL issue_order: lcd_cmd=%h, required %h", lcd_cmd, exp_cmd);
                    end
                end
                checks++;
                if (busy_prev !== 1'b0) begin
                    errors++;
                    $display("FAIL issue_while_busy: issued with lcd_busy=%b, required 0", busy_prev);
                end
            end
        end
        busy_prev = lcd_busy;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Controller model: busy for 20 cycles after each issue
    task automatic busy_step();
        if (lcd_cmd_valid) begin
            lcd_busy = 1'b1;
            bcnt     = 20;
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) lcd_busy = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        host_valid = 1'b0;
        host_cmd   = 4'h0;
        lcd_busy   = 1'b0;
        lcd_done   = 1'b0;
        bcnt       = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        host_valid = 1'b1;
        host_cmd   = 4'h5;
        lcd_busy   = 1'b0;
        lcd_done   = 1'b0;
        tick();
        tick();
        checks++;
        if (fifo_level !== 4'd0) begin errors++; $display("FAIL rst_level: %0d, required 0", fifo_level); end
        checks++;
        if (lcd_cmd_valid !== 1'b0 || lcd_cmd !== 4'h0) begin
            errors++; $display("FAIL rst_cmd: valid=%b cmd=%h, required 0/0", lcd_cmd_valid, lcd_cmd);
        end
        checks++;
        if (host_ready !== 1'b1 || sched_idle !== 1'b1) begin
            errors++; $display("FAIL rst_ready_idle: ready=%b idle=%b, required 1/1", host_ready, sched_idle);
        end
        checks++;
        if (sched_done !== 1'b0 || err_timeout !== 1'b0) begin
            errors++; $display("FAIL rst_sticky: done=%b err=%b, required 0/0", sched_done, err_timeout);
        end
        host_valid = 1'b0;
        reset      = 1'b0;
        tick();
    endtask

    task automatic test_single();
        host_cmd   = 4'h3;
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
        checks++;
        if (fifo_level !== 4'd1 || lcd_cmd_valid !== 1'b0) begin
            errors++; $display("FAIL single_push: level=%0d valid=%b, required 1/0", fifo_level, lcd_cmd_valid);
        end
        tick();
        checks++;
        if (lcd_cmd_valid !== 1'b1 || lcd_cmd !== 4'h3 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL single_issue: valid=%b cmd=%h level=%0d, required 1/3/0", lcd_cmd_valid, lcd_cmd, fifo_level);
        end
        checks++;
        if (sched_idle !== 1'b0) begin errors++; $display("FAIL single_busy_idle: %b, required 0", sched_idle); end
        tick();
        checks++;
        if (lcd_cmd_valid !== 1'b0 || lcd_cmd !== 4'h3 || sched_idle !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: valid=%b cmd=%h idle=%b, required 0/3/0", lcd_cmd_valid, lcd_cmd, sched_idle);
        end
        tick();
        checks++;
        if (sched_idle !== 1'b1) begin errors++; $display("FAIL single_idle_return: %b, required 1", sched_idle); end
    endtask

    task automatic test_busy_order();
        int start_iss;
        int k;
        start_iss  = n_issue;
        host_valid = 1'b1;
        host_cmd   = 4'h1; tick(); busy_step();
        host_cmd   = 4'h5; tick(); busy_step();
        host_cmd   = 4'h9; tick(); busy_step();
        host_valid = 1'b0;
        for (k = 0; k < 400; k++) begin
            if ((n_issue - start_iss) == 3 && sched_idle && !lcd_busy) break;
            tick();
            busy_step();
        end
        checks++;
        if (n_issue - start_iss != 3 || !sched_idle) begin
            errors++; $display("FAIL busy_order_count: issued %0d, required 3 then idle", n_issue - start_iss);
        end
        lcd_busy = 1'b0;
        bcnt     = 0;
    endtask

    function automatic logic [3:0] wrap_val(input int i);
        return 4'((i % 15) + 1);
    endfunction

    task automatic test_fill_wrap();
        int start_push;
        int start_iss;
        int idx;
        int k;
        start_push = n_push;
        start_iss  = n_issue;
        lcd_busy   = 1'b1;
        host_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            host_cmd = wrap_val(i);
            tick();
        end
        host_cmd = wrap_val(8);
        tick(); tick(); tick();
        checks++;
        if (fifo_level !== 4'd8 || host_ready !== 1'b0) begin
            errors++; $display("FAIL fill_full: level=%0d ready=%b, required 8/0", fifo_level, host_ready);
        end
        checks++;
        if (n_push - start_push != 8) begin
            errors++; $display("FAIL fill_overflow: accepted %0d, required 8", n_push - start_push);
        end
        lcd_busy = 1'b0;
        for (k = 0; k < 300; k++) begin
            tick();
            idx = n_push - start_push;
            if (idx < 16) host_cmd = wrap_val(idx);
            else host_valid = 1'b0;
            if (idx == 16 && (n_issue - start_iss) == 16 && sched_idle) break;
        end
        host_valid = 1'b0;
        checks++;
        if (n_issue - start_iss != 16 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL fill_wrap_drain: issued %0d level=%0d, required 16/0", n_issue - start_iss, fifo_level);
        end
    endtask

    task automatic test_write_done();
        int start_iss;
        int k;
        do_reset();
        start_iss  = n_issue;
        host_cmd   = 4'h0;
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
        for (k = 0; k < 10; k++) begin
            tick();
            if (lcd_cmd_valid) break;
        end
        checks++;
        if (lcd_cmd_valid !== 1'b1) begin
            errors++; $display("FAIL write_issue: valid=%b, required 1 within 10 cycles", lcd_cmd_valid);
        end
        lcd_busy = 1'b1;
        repeat (64) tick();
        checks++;
        if (sched_done !== 1'b0) begin errors++; $display("FAIL write_early_done: %b, required 0", sched_done); end
        lcd_busy = 1'b0;
        lcd_done = 1'b1;
        tick();
        lcd_done = 1'b0;
        checks++;
        if (sched_done !== 1'b1 || host_ready !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL write_done: done=%b ready=%b err=%b, required 1/0/0", sched_done, host_ready, err_timeout);
        end
        host_cmd   = 4'h2;
        host_valid = 1'b1;
        repeat (10) tick();
        host_valid = 1'b0;
        checks++;
        if (n_issue - start_iss != 1 || fifo_level !== 4'd0 || sched_done !== 1'b1) begin
            errors++;
            $display("FAIL done_terminal: issued %0d level=%0d done=%b, required 1/0/1",
                     n_issue - start_iss, fifo_level, sched_done);
        end
    endtask

    task automatic test_timeout();
        int k;
        do_reset();
        host_cmd   = 4'h7;
        host_valid = 1'b1;
        tick();
        host_cmd = 4'h4;
        tick();
        host_valid = 1'b0;
        lcd_busy   = 1'b1;
        checks++;
        if (lcd_cmd_valid !== 1'b1 || lcd_cmd !== 4'h7 || fifo_level !== 4'd1) begin
            errors++;
            $display("FAIL tmo_issue: valid=%b cmd=%h level=%0d, required 1/7/1", lcd_cmd_valid, lcd_cmd, fifo_level);
        end
        for (k = 0; k < 255; k++) begin
            lcd_done = (k == 10);
            tick();
        end
        lcd_done = 1'b0;
        checks++;
        if (err_timeout !== 1'b0 || sched_done !== 1'b0) begin
            errors++; $display("FAIL tmo_early: err=%b done=%b, required 0/0", err_timeout, sched_done);
        end
        tick();
        checks++;
        if (err_timeout !== 1'b1 || lcd_cmd_valid !== 1'b0 || fifo_level !== 4'd1) begin
            errors++;
            $display("FAIL tmo_fire: err=%b valid=%b level=%0d, required 1/0/1", err_timeout, lcd_cmd_valid, fifo_level);
        end
        tick();
        checks++;
        if (lcd_cmd_valid !== 1'b0) begin errors++; $display("FAIL tmo_hold_busy: valid=%b, required 0", lcd_cmd_valid); end
        lcd_busy = 1'b0;
        tick();
        checks++;
        if (lcd_cmd_valid !== 1'b1 || lcd_cmd !== 4'h4) begin
            errors++; $display("FAIL tmo_next: valid=%b cmd=%h, required 1/4", lcd_cmd_valid, lcd_cmd);
        end
        for (k = 0; k < 10; k++) begin
            if (sched_idle) break;
            tick();
        end
        checks++;
        if (sched_idle !== 1'b1) begin errors++; $display("FAIL tmo_idle: %b, required 1", sched_idle); end
    endtask

    task automatic test_reset_mid();
        lcd_busy   = 1'b0;
        host_valid = 1'b1;
        host_cmd   = 4'h6; tick();
        host_cmd   = 4'h8; tick();
        lcd_busy   = 1'b1;
        host_cmd   = 4'h9; tick();
        host_cmd   = 4'hA; tick();
        host_valid = 1'b0;
        checks++;
        if (fifo_level !== 4'd3 || err_timeout !== 1'b1) begin
            errors++; $display("FAIL mid_pre: level=%0d err=%b, required 3/1", fifo_level, err_timeout);
        end
`ifdef LCD_SCHED_STATS_EN
        checks++;
        if (issue_cnt !== 16'd3) begin errors++; $display("FAIL stats_count: %0d, required 3", issue_cnt); end
`endif
        reset = 1'b1;
        tick();
        checks++;
        if (fifo_level !== 4'd0 || lcd_cmd_valid !== 1'b0 || sched_done !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: level=%0d valid=%b done=%b err=%b, required 0/0/0/0",
                     fifo_level, lcd_cmd_valid, sched_done, err_timeout);
        end
`ifdef LCD_SCHED_STATS_EN
        checks++;
        if (issue_cnt !== 16'd0) begin errors++; $display("FAIL stats_reset: %0d, required 0", issue_cnt); end
`endif
        reset    = 1'b0;
        lcd_busy = 1'b0;
        tick();
        checks++;
        if (sched_idle !== 1'b1 || host_ready !== 1'b1) begin
            errors++; $display("FAIL mid_after: idle=%b ready=%b, required 1/1", sched_idle, host_ready);
        end
    endtask

    initial begin
        reset      = 1'b1;
        host_valid = 1'b0;
        host_cmd   = 4'h0;
        lcd_busy   = 1'b0;
        lcd_done   = 1'b0;
        test_reset();
        test_single();
        test_busy_order();
        test_fill_wrap();
        test_write_done();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_sched.md
Name: lcd_cmd_sched

Overview:
- Command scheduler sitting between a host or testbench command source and the LCD image-display controller.
- Buffers host commands in a small FIFO.
- Issues them one at a time to the controller's cmd/cmd_valid interface, only when the controller is not busy.
- Tracks command completion, detects the final Write (cmd 4'h0) completion via done, and flags hung operations with a timeout.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- TIMEOUT, 255, max cycles lcd_busy may stay high after an issue before error.
- GUARD, 1, cycles after an issue during which lcd_busy is ignored (controller busy latency).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- host_cmd  in  4  command opcode (0 Write … 0xB Mirror_Y).
- host_valid  in  1  host_cmd valid.
- host_ready  out  1  FIFO can accept; push when host_valid & host_ready.
- lcd_cmd  out  4  opcode to controller.
- lcd_cmd_valid  out  1  one-cycle issue strobe.
- lcd_busy  in  1  controller busy.
- lcd_done  in  1  controller finished Write.
- fifo_level  out  $clog2(DEPTH)+1  entries held.
- sched_idle  out  1  state IDLE and FIFO empty.
- sched_done  out  1  sticky, final Write completed.
- err_timeout  out  1  sticky, busy timeout occurred.

Behaviour:
- Reset (synchronous, active-high, wins over all other activity including mid-operation):
  - FIFO emptied; state IDLE.
  - lcd_cmd=0, lcd_cmd_valid=0, fifo_level=0.
  - host_ready=1, sched_idle=1, sched_done=0, err_timeout=0.
- All outputs are registered except host_ready, fifo_level and sched_idle, which are decoded from registers.
- FIFO:
  - Circular, read/write pointers wrap modulo DEPTH.
  - host_ready = !full & state!=DONE.
  - When full, host_ready=0 even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave the level unchanged.
  - host_cmd is ignored when host_ready=0; no overflow is possible.
- State machine:
  - IDLE: if FIFO non-empty and lcd_busy==0 -> pop the head, drive lcd_cmd=head and lcd_cmd_valid=1 for exactly one cycle, load guard counter=GUARD, go to WAIT.
  - Issue latency: an entry pushed at edge t into an empty FIFO in IDLE, with busy low, appears on lcd_cmd_valid after edge t+1.
  - WAIT: the guard counter decrements to 0 while lcd_busy is ignored. After that:
    - lcd_busy==0 and the issued opcode != 0 -> IDLE. The next issue is permitted in the same cycle the state returns to IDLE, so back-to-back issues are spaced GUARD+2 cycles minimum.
    - Issued opcode == 0 -> go to WDONE.
  - WDONE: wait for lcd_done==1, then set sched_done and go to DONE.
  - DONE: terminal. No further issues; host_ready=0; remaining FIFO entries are held. Only reset exits.
- Timeout:
  - A cycle counter runs in WAIT and WDONE after the guard expires while lcd_busy==1 (WAIT) or lcd_done==0 (WDONE).
  - If it reaches TIMEOUT: set err_timeout, return to IDLE, discard the in-flight command. The FIFO continues draining.
  - The counter clears on each state entry.
- Opcodes 0xC–0xF are passed through unchanged; the scheduler does not interpret them except 0x0.
- lcd_done asserted outside WDONE is ignored.
- lcd_cmd holds its last value when lcd_cmd_valid=0.

Optional Feature:
- Macro LCD_SCHED_STATS_EN.
- Defined: adds output port issue_cnt [15:0], counting lcd_cmd_valid pulses since reset. Saturates at 0xFFFF; cleared by reset.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, lcd_busy=0; push 0x3 at cycle 2 -> lcd_cmd=0x3 with lcd_cmd_valid=1 for exactly one cycle at cycle 3; sched_idle returns to 1 at cycle 3+GUARD+1; fifo_level 1→0.
- Hold lcd_busy=1 for 20 cycles after each issue; push 0x1,0x5,0x9 back-to-back -> issued in order, each only after busy falls; never two valids while busy=1.
- Push 9 entries with lcd_busy=1 throughout, DEPTH=8 -> host_ready=0 at level 8; 9th not accepted until a pop; pointer wrap verified after 16 total pushes with no reordering.
- Push 0x0; drive lcd_busy high 64 cycles then lcd_done=1 -> sched_done=1 the cycle after; host_ready=0; a later push of 0x2 is never issued.
- Hold lcd_busy=1 permanently after an issue, TIMEOUT=255 -> err_timeout=1 after 255 cycles post-guard; state returns to IDLE; next issue waits for busy=0.
- Assert reset during WAIT with 3 entries queued -> next cycle: fifo_level=0, lcd_cmd_valid=0, sched_done=0, err_timeout=0; with LCD_SCHED_STATS_EN, issue_cnt=0.
